// File: rtl/ham_seq_ctrl.sv
// Sequential 32-bit popcount controller: feeds one byte per cycle to a shared
// 8-bit popcount unit and accumulates the returned counts into a 6-bit result.
module ham_seq_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mode,
    input  logic [31:0] operand,
    input  logic        abort,
    output logic [7:0]  ham_in,
    input  logic [3:0]  ham_out,
    output logic        busy,
    output logic        done,
    output logic [5:0]  result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [5:0]  acc_q, acc_d;
    logic [31:0] op_q, op_d;
    logic        mode_q, mode_d;
    logic [5:0]  result_q, result_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [7:0]  ham_in_q, ham_in_d;

    logic        accept;
    logic [5:0]  sum;

    function automatic logic [7:0] sel_byte(input logic [31:0] w,
                                            input logic        inv,
                                            input logic [1:0]  i);
        logic [7:0] b;
        case (i)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        return b ^ {8{inv}};
    endfunction

    assign accept = start && (state_q == IDLE || state_q == DONE);
    assign sum    = acc_q + {2'b00, ham_out};

    // ham_in is registered one cycle ahead so it is stable for the whole COUNT cycle.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        op_d     = op_q;
        mode_d   = mode_q;
        result_d = result_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        ham_in_d = 8'h00;

        case (state_q)
            COUNT: begin
                if (abort) begin
                    state_d = IDLE;
                    acc_d   = 6'd0;
                    idx_d   = 2'd0;
                end else if (idx_q == 2'd3) begin
                    result_d = sum;
                    acc_d    = sum;
                    idx_d    = 2'd0;
                    state_d  = DONE;
                    done_d   = 1'b1;
                end else begin
                    acc_d    = sum;
                    idx_d    = idx_q + 2'd1;
                    busy_d   = 1'b1;
                    ham_in_d = sel_byte(op_q, mode_q, idx_q + 2'd1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            op_d     = operand;
            mode_d   = mode;
            acc_d    = 6'd0;
            idx_d    = 2'd0;
            state_d  = COUNT;
            busy_d   = 1'b1;
            done_d   = 1'b0;
            ham_in_d = sel_byte(operand, mode, 2'd0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= 2'd0;
            acc_q    <= 6'd0;
            op_q     <= 32'd0;
            mode_q   <= 1'b0;
            result_q <= 6'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ham_in_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            op_q     <= op_d;
            mode_q   <= mode_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ham_in_q <= ham_in_d;
        end
    end

    assign ham_in = ham_in_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_ham_seq_ctrl.sv
// Directed, table-driven bench for ham_seq_ctrl with a behavioural popcount unit.
module tb_ham_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        mode;
    logic [31:0] operand;
    logic        abort;
    logic [7:0]  ham_in;
    logic [3:0]  ham_out;
    logic        busy;
    logic        done;
    logic [5:0]  result;

    int checks;
    int failures;

    typedef struct {
        logic [31:0]      operand;
        logic             mode;
        logic [3:0][7:0]  bytes;
        logic [5:0]       result;
    } vec_t;

    vec_t vecs[6];

    ham_seq_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .mode    (mode),
        .operand (operand),
        .abort   (abort),
        .ham_in  (ham_in),
        .ham_out (ham_out),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    // Shared popcount unit model
    assign ham_out = 4'($countones(ham_in));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] op, input logic md);
        start   = 1'b1;
        operand = op;
        mode    = md;
        tick();
        start   = 1'b0;
    endtask

    task automatic runVector(input vec_t v);
        applyStimulus(v.operand, v.mode);
        for (int i = 0; i < 4; i++) begin
            checkOutput("busy_count", {31'd0, busy}, 32'd1);
            checkOutput("done_count", {31'd0, done}, 32'd0);
            checkOutput("ham_in_byte", {24'd0, ham_in}, {24'd0, v.bytes[i]});
            tick();
        end
        checkOutput("done_pulse", {31'd0, done}, 32'd1);
        checkOutput("busy_done", {31'd0, busy}, 32'd0);
        checkOutput("result", {26'd0, result}, {26'd0, v.result});
        checkOutput("ham_in_done", {24'd0, ham_in}, 32'd0);
        tick();
        checkOutput("done_one_cycle", {31'd0, done}, 32'd0);
        checkOutput("result_hold", {26'd0, result}, {26'd0, v.result});
    endtask

    initial begin
        int done_seen;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        start    = 1'b0;
        mode     = 1'b0;
        operand  = 32'd0;
        abort    = 1'b0;

        vecs[0] = '{32'hFFFFFFFF, 1'b0, {8'hFF, 8'hFF, 8'hFF, 8'hFF}, 6'd32};
        vecs[1] = '{32'h0F0F00FF, 1'b0, {8'h0F, 8'h0F, 8'h00, 8'hFF}, 6'd16};
        vecs[2] = '{32'h00000000, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hFF}, 6'd32};
        vecs[3] = '{32'h80000001, 1'b1, {8'h7F, 8'hFF, 8'hFF, 8'hFE}, 6'd30};
        vecs[4] = '{32'h12345678, 1'b0, {8'h12, 8'h34, 8'h56, 8'h78}, 6'd13};
        vecs[5] = '{32'hA5A5A5A5, 1'b1, {8'h5A, 8'h5A, 8'h5A, 8'h5A}, 6'd16};

        #1;
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_result", {26'd0, result}, 32'd0);
        checkOutput("reset_ham_in", {24'd0, ham_in}, 32'd0);
        tick();
        rst = 1'b0;

        for (int v = 0; v < 6; v++) runVector(vecs[v]);

        // Start pulses during COUNT must be ignored
        applyStimulus(32'hFFFFFFFF, 1'b0);
        done_seen = 0;
        for (int k = 1; k <= 8; k++) begin
            if (k <= 3) begin
                start   = 1'b1;
                operand = 32'h00000000;
                mode    = 1'b0;
                checkOutput("ignore_ham_in", {24'd0, ham_in}, 32'hFF);
            end else begin
                start = 1'b0;
            end
            if (done) begin
                done_seen++;
                checkOutput("ignore_result", {26'd0, result}, 32'd32);
            end
            tick();
        end
        checkOutput("ignore_done_count", done_seen, 32'd1);

        // Abort at the second COUNT cycle after a result of 16
        runVector(vecs[1]);
        applyStimulus(32'hFFFFFFFF, 1'b0);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_ham_in", {24'd0, ham_in}, 32'd0);
        done_seen = 0;
        for (int k = 0; k < 6; k++) begin
            if (done) done_seen++;
            checkOutput("abort_result", {26'd0, result}, 32'd16);
            tick();
        end
        checkOutput("abort_no_done", done_seen, 32'd0);

        // Start held high: back-to-back counts, abort in DONE ignored
        applyStimulus(32'h80000001, 1'b1);
        start = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            checkOutput("b2b_done", {31'd0, done}, {31'd0, (k % 5) == 0});
            checkOutput("b2b_busy", {31'd0, busy}, {31'd0, (k % 5) != 0});
            if ((k % 5) == 0) checkOutput("b2b_result", {26'd0, result}, 32'd30);
            abort = (k == 10);
            if (k == 15) start = 1'b0;
            tick();
        end
        abort = 1'b0;
        checkOutput("b2b_idle", {31'd0, busy}, 32'd0);

        // Asynchronous reset mid-COUNT
        applyStimulus(32'hFFFFFFFF, 1'b0);
        tick();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_busy", {31'd0, busy}, 32'd0);
        checkOutput("arst_done", {31'd0, done}, 32'd0);
        checkOutput("arst_result", {26'd0, result}, 32'd0);
        checkOutput("arst_ham_in", {24'd0, ham_in}, 32'd0);
        tick();
        rst = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 8; k++) begin
            if (done) done_seen++;
            tick();
        end
        checkOutput("arst_no_done", done_seen, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
